// File: rtl/fp_pkg.sv
// Shared floating-point definitions: status word bit positions, the rounding
// mode constant, canonical special-value builders and the rounding decision.
package fp_pkg;

  localparam int ST_ZERO     = 0;
  localparam int ST_INFINITY = 1;
  localparam int ST_INVALID  = 2;
  localparam int ST_TINY     = 3;
  localparam int ST_HUGE     = 4;
  localparam int ST_INEXACT  = 5;
  localparam int ST_HUGEINT  = 6;
  localparam int ST_COMPSPEC = 7;

  localparam logic [2:0] RNE = 3'b000;

  // Signed infinity, LSB-aligned in a 76-bit word; callers truncate to their width.
  function automatic logic [75:0] fp_inf(input int sw, input int ew, input logic sign);
    logic [75:0] r;
    r = ((76'd1 << ew) - 76'd1) << sw;
    r = r | ({75'd0, sign} << (sw + ew));
    return r;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction 0...01.
  function automatic logic [75:0] fp_nan(input int sw, input int ew);
    logic [75:0] r;
    r = fp_inf(sw, ew, 1'b0) | 76'd1;
    return r;
  endfunction

  // Increment decision from the kept LSB and the guard/sticky bits.
  function automatic logic round_up(input logic [2:0] mode, input logic lsb,
                                    input logic guard, input logic sticky);
    case (mode)
      RNE:     return guard & (sticky | lsb);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_mult_core.sv
// Combinational FP multiply: unpack, full-width significand product,
// normalise (left for denormal inputs, right for underflow), RNE round, pack.
module fp_mult_core
  import fp_pkg::*;
#(
  parameter int sig_width       = 17,
  parameter int exp_width       = 6,
  parameter int ieee_compliance = 1
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int   W    = sig_width + exp_width + 1;
  localparam int   MW   = sig_width + 1;
  localparam int   PW   = 2 * MW;
  localparam int   BIAS = (1 << (exp_width - 1)) - 1;
  localparam int   EMAX = (1 << exp_width) - 1;
  localparam logic IEEE = (ieee_compliance != 0);

  // Leading-zero count of the raw product (PW when the product is zero).
  function automatic int count_lz(input logic [PW-1:0] v);
    int n;
    logic [PW-1:0] t;
    n = PW;
    for (int i = 0; i < PW; i++) begin
      t = v >> i;
      if (t[0]) n = PW - 1 - i;
    end
    return n;
  endfunction

  logic                 sz;
  logic [exp_width-1:0] ea, eb;
  logic [sig_width-1:0] fa, fb, frac;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MW-1:0]        ma, mb, mant;
  logic [MW:0]          mant_r;
  logic [PW-1:0]        prod, norm, shifted;
  logic                 guard, sticky, lost, inc;
  int                   ea_eff, eb_eff, lz, e_norm, rsh, fexp;

  // Full datapath plus special-case selection into the packed result and flags.
  always_comb begin
    // NOTE: every output and temporary gets a value on every path so no latch is inferred.
    z      = '0;
    status = '0;
    sz     = a[W-1] ^ b[W-1];
    ea     = a[W-2 -: exp_width];
    eb     = b[W-2 -: exp_width];
    fa     = a[sig_width-1:0];
    fb     = b[sig_width-1:0];

    a_nan  = IEEE & (&ea) & (|fa);
    b_nan  = IEEE & (&eb) & (|fb);
    a_inf  = (&ea) & (~(|fa) | ~IEEE);
    b_inf  = (&eb) & (~(|fb) | ~IEEE);
    a_zero = ~(|ea) & (~(|fa) | ~IEEE);
    b_zero = ~(|eb) & (~(|fb) | ~IEEE);

    // Denormals carry a hidden 0 and the minimum exponent of 1.
    ma     = {|ea, fa};
    mb     = {|eb, fb};
    ea_eff = (|ea) ? int'(ea) : 1;
    eb_eff = (|eb) ? int'(eb) : 1;

    prod   = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
    lz     = count_lz(prod);
    norm   = prod << lz;
    e_norm = ea_eff + eb_eff - BIAS + 1 - lz;

    // Below the normal range: shift into denormal position, keeping shifted-out bits as sticky.
    rsh = 0;
    if (e_norm < 1) rsh = (1 - e_norm > PW) ? PW : 1 - e_norm;
    shifted = norm >> rsh;
    lost    = |(norm & ~({PW{1'b1}} << rsh));

    mant   = shifted[PW-1 -: MW];
    guard  = shifted[PW-1-MW];
    sticky = (|shifted[PW-2-MW:0]) | lost;
    inc    = round_up(RNE, mant[0], guard, sticky);
    mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};

    // A denormal that rounds up to the hidden-bit position becomes the smallest normal.
    fexp = (e_norm < 1) ? int'(mant_r[MW-1]) : e_norm + int'(mant_r[MW]);
    frac = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MW-2:0];

    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      status[ST_INVALID] = 1'b1;
      if (IEEE) begin
        z = W'(fp_nan(sig_width, exp_width));
      end else begin
        z = W'(fp_inf(sig_width, exp_width, 1'b0));
        status[ST_INFINITY] = 1'b1;
      end
    end else if (a_inf | b_inf) begin
      z = W'(fp_inf(sig_width, exp_width, sz));
      status[ST_INFINITY] = 1'b1;
    end else if (a_zero | b_zero) begin
      z = {sz, {(W-1){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (!IEEE && e_norm < 1) begin
      z = {sz, {(W-1){1'b0}}};
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else if (fexp >= EMAX) begin
      z = W'(fp_inf(sig_width, exp_width, sz));
      status[ST_INFINITY] = 1'b1;
      status[ST_HUGE]     = 1'b1;
      status[ST_INEXACT]  = 1'b1;
    end else begin
      z = {sz, exp_width'(fexp), frac};
      status[ST_ZERO]    = (fexp == 0) && (frac == '0);
      status[ST_TINY]    = (e_norm < 1);
      status[ST_INEXACT] = guard | sticky;
    end
    status[ST_HUGEINT]  = 1'b0;
    status[ST_COMPSPEC] = 1'b0;
  end

endmodule

// File: rtl/dw_fp_mult_inst.sv
// Registered FP multiplier: combinational core followed by one output stage
// (result, status, valid). Defining DW_FP_MULT_IN_REG_EN adds an input
// register stage on the operands and valid, giving a latency of 2 cycles.
module dw_fp_mult_inst
  import fp_pkg::*;
#(
  parameter int sig_width       = 17,
  parameter int exp_width       = 6,
  parameter int ieee_compliance = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [sig_width+exp_width:0] inst_a,
  input  logic [sig_width+exp_width:0] inst_b,
  output logic                         out_valid,
  output logic [sig_width+exp_width:0] z_inst,
  output logic [7:0]                   status_inst
);

  localparam int W = sig_width + exp_width + 1;

  logic [W-1:0] core_a, core_b, core_z;
  logic [7:0]   core_status;
  logic         core_v;

`ifdef DW_FP_MULT_IN_REG_EN
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         v_q, v_d;

  // Input stage captures operands and valid unconditionally.
  always_comb begin
    a_d = inst_a;
    b_d = inst_b;
    v_d = in_valid;
  end

  // Input stage flops, cleared by reset so an in-flight operation is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v_q <= v_d;
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_v = v_q;
`else
  assign core_a = inst_a;
  assign core_b = inst_b;
  assign core_v = in_valid;
`endif

  fp_mult_core #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(ieee_compliance)
  ) u_core (
    .a     (core_a),
    .b     (core_b),
    .z     (core_z),
    .status(core_status)
  );

  logic [W-1:0] z_q, z_d;
  logic [7:0]   status_q, status_d;
  logic         out_valid_q, out_valid_d;

  // Output stage loads a new result only for valid operations, otherwise holds.
  always_comb begin
    out_valid_d = core_v;
    z_d         = z_q;
    status_d    = status_q;
    if (core_v) begin
      z_d      = core_z;
      status_d = core_status;
    end
  end

  // Output flops; reset takes priority over a simultaneous valid operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
    if (rst) begin
      z_q         <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z_inst      = z_q;
  assign status_inst = status_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_dw_fp_mult_inst.sv
// Self-checking bench for dw_fp_mult_inst (default 1/6/17 format): directed
// vectors with literal expectations plus random back-to-back traffic checked
// against an integer-value RNE reference model.
module tb_dw_fp_mult_inst;

  logic        clk, rst, in_valid, out_valid;
  logic [23:0] inst_a, inst_b, z_inst;
  logic [7:0]  status_inst;

  int n_checks;
  int n_errors;

  logic        exp_valid;
  logic [23:0] exp_z;
  logic [7:0]  exp_st;

`ifdef DW_FP_MULT_IN_REG_EN
  localparam int LAT = 2;
  logic        s1_v;
  logic [23:0] s1_a, s1_b;
`else
  localparam int LAT = 1;
`endif

  dw_fp_mult_inst #(
    .sig_width      (17),
    .exp_width      (6),
    .ieee_compliance(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .inst_a     (inst_a),
    .inst_b     (inst_b),
    .out_valid  (out_valid),
    .z_inst     (z_inst),
    .status_inst(status_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: exact value m*2^x, rounded to the nearest multiple of the
  // format's ulp at that magnitude (ties to even), then encoded.
  function automatic logic [31:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, tiny, inexact;
    int     ea, eb, xa, xb, x, msb, k, u, sh, biased;
    longint fa, fb, ma, mb, m, q, r, half;
    s  = a[23] ^ b[23];
    ea = int'(a[22:17]);
    eb = int'(b[22:17]);
    fa = longint'(a[16:0]);
    fb = longint'(b[16:0]);
    a_nan  = (ea == 63) && (fa != 0);
    b_nan  = (eb == 63) && (fb != 0);
    a_inf  = (ea == 63) && (fa == 0);
    b_inf  = (eb == 63) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {8'h04, 24'h7E0001};
    if (a_inf || b_inf) return {8'h02, s, 6'h3F, 17'h0};
    if (a_zero || b_zero) return {8'h01, s, 23'h0};
    ma = (ea == 0) ? fa : fa + 64'sd131072;
    mb = (eb == 0) ? fb : fb + 64'sd131072;
    xa = ((ea == 0) ? 1 : ea) - 48;
    xb = ((eb == 0) ? 1 : eb) - 48;
    m  = ma * mb;
    x  = xa + xb;
    msb = 0;
    for (int i = 0; i < 63; i++) if (m >= (64'sd1 <<< i)) msb = i;
    k    = msb + x;
    tiny = (k < -30);
    u    = (k - 17 > -47) ? k - 17 : -47;
    sh   = u - x;
    if (sh < 0) sh = 0;
    q    = m >>> sh;
    r    = m - (q <<< sh);
    half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
    inexact = (r != 0);
    if (sh > 0 && (r > half || (r == half && q[0]))) q = q + 1;
    if (q == 64'sd262144) begin
      q = 64'sd131072;
      u = u + 1;
    end
    biased = (q < 64'sd131072) ? 0 : u + 48;
    if (biased >= 63) return {8'h32, s, 6'h3F, 17'h0};
    return {2'b00, inexact, 1'b0, tiny, 2'b00, (q == 0), s, 6'(biased), q[16:0]};
  endfunction

  // Advance the expected outputs by one clock edge.
  task automatic model_edge(input logic v, input logic [23:0] a, input logic [23:0] b, input logic r);
    logic        ov;
    logic [23:0] oa, ob;
    logic [31:0] res;
    if (r) begin
      exp_valid = 1'b0;
      exp_z     = '0;
      exp_st    = '0;
`ifdef DW_FP_MULT_IN_REG_EN
      s1_v = 1'b0;
      s1_a = '0;
      s1_b = '0;
`endif
    end else begin
`ifdef DW_FP_MULT_IN_REG_EN
      ov = s1_v; oa = s1_a; ob = s1_b;
      s1_v = v;  s1_a = a;  s1_b = b;
`else
      ov = v; oa = a; ob = b;
`endif
      exp_valid = ov;
      if (ov) begin
        res    = ref_mul(oa, ob);
        exp_z  = res[23:0];
        exp_st = res[31:24];
      end
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic cycle(input logic v, input logic [23:0] a, input logic [23:0] b, input logic r);
    rst      = r;
    in_valid = v;
    inst_a   = a;
    inst_b   = b;
    @(posedge clk);
    model_edge(v, a, b, r);
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("z_inst", 32'(z_inst), 32'(exp_z));
    check("status_inst", 32'(status_inst), 32'(exp_st));
  endtask

  task automatic dir(input logic [23:0] a, input logic [23:0] b,
                     input logic [23:0] ez, input logic [7:0] est);
    cycle(1'b1, a, b, 1'b0);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 24'h0, 24'h0, 1'b0);
    check("dir_valid", 32'(out_valid), 32'd1);
    check("dir_z", 32'(z_inst), 32'(ez));
    check("dir_status", 32'(status_inst), 32'(est));
  endtask

  function automatic logic [23:0] rand_op();
    logic [5:0]  e;
    logic [16:0] f;
    e = 6'($urandom);
    f = 17'($urandom);
    case ($urandom_range(0, 9))
      0: e = 6'h00;
      1: e = 6'h3F;
      2: f = 17'h0;
      3: begin e = 6'h00; f = 17'h0; end
      4, 5: e = 6'($urandom_range(20, 42));
      6: e = 6'($urandom_range(0, 8));
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inst_a    = '0;
    inst_b    = '0;
    exp_valid = 1'b0;
    exp_z     = '0;
    exp_st    = '0;
`ifdef DW_FP_MULT_IN_REG_EN
    s1_v = 1'b0;
    s1_a = '0;
    s1_b = '0;
`endif
    @(negedge clk);
    cycle(1'b0, 24'h0, 24'h0, 1'b1);
    cycle(1'b1, 24'h3F0000, 24'h3F0000, 1'b1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_z", 32'(z_inst), 32'd0);
    check("reset_status", 32'(status_inst), 32'd0);

    dir(24'h3F0000, 24'h3F0000, 24'h404000, 8'h00);
    dir(24'h3E0000, 24'hC00000, 24'hC00000, 8'h00);
    dir(24'h000000, 24'hC00000, 24'h800000, 8'h01);
    dir(24'h7E0000, 24'h000000, 24'h7E0001, 8'h04);
    dir(24'h7E0000, 24'h3E0000, 24'h7E0000, 8'h02);
    dir(24'h7DFFFF, 24'h400000, 24'h7E0000, 8'h32);
    dir(24'h000001, 24'h3C0000, 24'h000000, 8'h29);
    dir(24'h7E0005, 24'h3E0000, 24'h7E0001, 8'h04);
    dir(24'h000002, 24'h3C0000, 24'h000001, 8'h08);
    dir(24'h800000, 24'h3E0000, 24'h800000, 8'h01);
    cycle(1'b1, 24'h2EF0A3, 24'h2EF0A3, 1'b0);
    cycle(1'b0, 24'h0, 24'h0, 1'b0);
    cycle(1'b0, 24'h0, 24'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      logic [23:0] ra, rb;
      logic        rv;
      ra = rand_op();
      rb = rand_op();
      rv = ($urandom_range(0, 7) != 0);
      if (i == 300) begin
        cycle(1'b1, ra, rb, 1'b1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_z", 32'(z_inst), 32'd0);
        check("midrst_status", 32'(status_inst), 32'd0);
      end else begin
        cycle(rv, ra, rb, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dw_fp_mult_inst.md
# dw_fp_mult_inst

Parameterised IEEE-754-style floating-point multiplier with a registered result, used as the FP multiply datapath element of the arithmetic pipeline. Takes two packed operands, computes their product with round-to-nearest-even, and returns the packed result plus an 8-bit exception status word one clock later. The default format is a 24-bit float: 1 sign bit, 6 exponent bits, 17 fraction bits.

## Interface
- sig_width, 17: fraction (stored significand) width, 2..60
- exp_width, 6: exponent width, 3..15; bias = 2^(exp_width-1)-1 (31 by default)
- ieee_compliance, 1: 1 = full denormal/NaN support; 0 = denormal inputs treated as zero, NaN output as infinity
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid this cycle
- inst_a  in  sig_width+exp_width+1  operand A {sign, exponent, fraction}
- inst_b  in  sig_width+exp_width+1  operand B, same format
- out_valid  out  1  z_inst/status_inst valid
- z_inst  out  sig_width+exp_width+1  product
- status_inst  out  8  exception flags

## Operation
- Sign = sign_a XOR sign_b, for every result including zero and infinity.
- Normal: exponent_a + exponent_b - bias; significand = (1.frac_a) x (1.frac_b), full 2(sig_width+1)-bit product, normalised by at most one left position for normal inputs and multiple positions for denormal inputs.
- Rounding fixed to round-to-nearest-even; no rounding-mode input. Guard/round/sticky from the discarded product bits.
- Rounding carry-out renormalises (exponent +1).
- Underflow: result shifted right into denormal range (ieee_compliance=1) with sticky preserved, then rounded; rounding to zero yields signed zero.
- Overflow (biased exponent >= all-ones after rounding): result = signed infinity.
- Special cases, in priority order: any NaN input, or inf x 0 -> canonical NaN = exponent all ones, fraction 0...01, sign 0; inf x finite -> signed infinity; zero x finite -> signed zero.
- status_inst bits: [0] zero, [1] infinity, [2] invalid (NaN produced from inf x 0 or NaN input), [3] tiny (nonzero result magnitude below 2^(1-bias) before rounding, or rounding to zero from nonzero), [4] huge (overflow to infinity), [5] inexact (any discarded nonzero bits, always set with huge), [6] 0, [7] 0.
- Exact products of finite normals set no flags except zero where applicable.

## Timing
- Latency 1 cycle: operands sampled on clock edge with in_valid=1 appear on z_inst/status_inst with out_valid=1 after that edge.
- Fully pipelined: one new operation accepted per cycle; no backpressure.
- in_valid=0: out_valid drops to 0 next cycle; z_inst/status_inst hold previous values.
- Reset: out_valid=0, z_inst=0, status_inst=0 on the next edge; rst wins over a simultaneous in_valid; an operation in flight during reset is discarded.

## Configuration
- DW_FP_MULT_IN_REG_EN defined: extra input register stage on inst_a/inst_b/in_valid (reset to 0); latency becomes 2 cycles, throughput unchanged.
- Undefined: operands feed the combinational multiplier directly; latency 1.

## Structure
- Shared package fp_pkg: status bit index constants (ST_ZERO..ST_COMPSPEC), canonical NaN/infinity construction functions, rounding-mode constant RNE.
- One sub-module fp_mult_core: purely combinational unpack/multiply/normalise/round/pack. The top level holds the valid pipeline, the registers and the optional input stage.

## Test plan
- 0x3F0000 (1.5) x 0x3F0000 -> z=0x404000 (2.25), status=0x00, out_valid one cycle after in_valid.
- 0x3E0000 (1.0) x 0xC00000 (-2.0) -> 0xC00000, status=0x00; 0x000000 x 0xC00000 -> 0x800000, status=0x01.
- 0x7E0000 (inf) x 0x000000 -> 0x7E0001, status=0x04; 0x7E0000 x 0x3E0000 -> 0x7E0000, status=0x02.
- 0x7DFFFF (max normal) x 0x400000 (2.0) -> 0x7E0000, status=0x32.
- 0x000001 (min denormal) x 0x3C0000 (0.5) -> 0x000000 (tie to even), status=0x29.
- 0x2EF0A3 x 0x2EF0A3 and back-to-back random operands every cycle -> match bit-exact software RNE model. Assert rst mid-stream -> out_valid=0, z_inst=0, status_inst=0 next cycle.
